general_register_freelist: RTL
==============================

GENERAL_REGISTER_FREELIST -- requirements
Module: general_register_freelist

Interface
REQ-001 The block SHALL have parameters: PREG_NUM 64 (number of physical register entries); PREG_W 6 (physical register name width).
REQ-002 The block SHALL have ports:
- iCLOCK  in  1  the single clock.
- inRESET  in  1  reset, synchronous and active-low.
- iFREE_RESTART  in  1  rollback or flush.
- iENTRY_FREELIST_REQ  in  64  per-entry release request, bit n = entry n.
- oENTRY_FREELIST_REGIST_VALID  out  64  per-entry acceptance acknowledge.
- iALLOC_0_REQ  in  1  rename slot 0 consumes a name.
- iALLOC_1_REQ  in  1  rename slot 1 consumes a name.
- oALLOC_0_VALID  out  1  a free name is available for slot 0.
- oALLOC_0_REGNAME  out  6  name offered to slot 0.
- oALLOC_1_VALID  out  1  a second free name is available for slot 1.
- oALLOC_1_REGNAME  out  6  name offered to slot 1.
- oFREE_COUNT  out  7  number of names held, 0..64.
REQ-003 The reset SHALL be synchronous and active-low, with one clock: iCLOCK, inRESET.

Function
REQ-004 The name store SHALL be a circular FIFO of 64 x 6-bit entries, with 6-bit read and write pointers that wrap modulo 64 and a 7-bit count.
REQ-005 Request acceptance per cycle:
- The lowest-indexed asserted bit of iENTRY_FREELIST_REQ SHALL be picked first, and the next-lowest second.
- At most 2 bits SHALL be picked per cycle.
- The number picked SHALL be limited to min(2, 64 - count + pops this cycle).
REQ-006 oENTRY_FREELIST_REGIST_VALID SHALL be combinational from the current inputs and assert exactly the picked bits, so an entry's request drops one cycle after acceptance and is never granted twice.
REQ-007 Picked names SHALL be written at the clock edge; the lower index goes to wptr and the higher to wptr+1. wptr SHALL advance by the number picked.
REQ-008 Allocation outputs:
- oALLOC_0_VALID = (count >= 1); oALLOC_0_REGNAME = fifo[rptr].
- oALLOC_1_VALID = (count >= 2); oALLOC_1_REGNAME = fifo[rptr+1].
- A name written this cycle SHALL NOT be offered until the next cycle (no bypass).
REQ-009 Pops per cycle:
- pop0 = iALLOC_0_REQ && oALLOC_0_VALID.
- pop1 = iALLOC_1_REQ && oALLOC_1_VALID && pop0.
- iALLOC_1_REQ without iALLOC_0_REQ SHALL pop nothing.
- rptr SHALL advance by pop0 + pop1.
REQ-010 Count update: count_next = count + pushes - pops, with push and pop permitted in the same cycle. count SHALL never exceed 64 or underflow.
REQ-011 iFREE_RESTART high SHALL take precedence over pushes and pops. On such a cycle:
- rptr, wptr and count clear to 0.
- oENTRY_FREELIST_REGIST_VALID is all zero.
- oALLOC_*_VALID are forced to 0.
- Entries re-request from the next cycle onward.
REQ-012 oFREE_COUNT SHALL equal the registered count.

Reset
REQ-013 While inRESET is 0 at a clock edge, the block SHALL clear: rptr = 0, wptr = 0, count = 0, FIFO contents = 0.
REQ-014 Output values while in reset and on the first cycle after it: oALLOC_0_VALID = 0, oALLOC_1_VALID = 0, both REGNAMEs = 0, oFREE_COUNT = 0, and oENTRY_FREELIST_REGIST_VALID = 0 while inRESET is low.
REQ-015 A reset asserted mid-operation SHALL discard all held names. Entries repopulate the list through requests.

Structure
REQ-016 PREG_NUM, PREG_W and the count width (PREG_W+1) SHALL live in the shared scheduler constants package.
REQ-017 The two-winner priority picker SHALL be a sub-module, general_register_freelist_pick2. It is combinational, takes a 64-bit request vector and a 2-bit limit, and outputs two valid flags, two 6-bit indices and a 64-bit grant vector.

Verification
REQ-018 Reset fill: entries 32..63 request after reset -> accepted 2 per cycle in ascending order; count reaches 32 after 16 cycles; oALLOC_0_REGNAME = 32 and oALLOC_1_REGNAME = 33.
REQ-019 Single grant: iENTRY_FREELIST_REQ = bits {5,9,40} -> grant vector = {5,9} that cycle; bit 40 is granted the next cycle; no bit is granted twice.
REQ-020 Simultaneous traffic: count = 1 holding name 7, both allocs requested, one new request (entry 12) -> only name 7 is popped, 12 is pushed; next cycle count = 1 and oALLOC_0_REGNAME = 12.
REQ-021 Wrap and full: cycle 70 names through the FIFO -> pointers wrap with order preserved. At count = 64, with no pops, a new request is not granted.
REQ-022 Restart: count = 10 plus an active request, with iFREE_RESTART = 1 -> no grant; next cycle count = 0 and both VALIDs = 0. Re-requests are then accepted in index order.

Source files
------------

// File: rtl/general_register_freelist_pkg.sv
// Shared scheduler constants for the physical register freelist.
package general_register_freelist_pkg;
  localparam int PREG_NUM = 64;
  localparam int PREG_W   = 6;
  localparam int CNT_W    = PREG_W + 1;
endpackage

// File: rtl/general_register_freelist_pick2.sv
// Two-winner lowest-index priority picker, capped by a 0..2 limit.
module general_register_freelist_pick2
  import general_register_freelist_pkg::*;
#(
  parameter int PREG_NUM_P = PREG_NUM,
  parameter int PREG_W_P   = PREG_W
) (
  input  logic [PREG_NUM_P-1:0] req,
  input  logic [1:0]            limit,
  output logic                  valid_0,
  output logic                  valid_1,
  output logic [PREG_W_P-1:0]   idx_0,
  output logic [PREG_W_P-1:0]   idx_1,
  output logic [PREG_NUM_P-1:0] grant
);

  always_comb begin
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    idx_0   = '0;
    idx_1   = '0;
    grant   = '0;
    for (int i = 0; i < PREG_NUM_P; i++) begin
      if (req[i]) begin
        if (!valid_0 && limit >= 2'd1) begin
          valid_0  = 1'b1;
          idx_0    = PREG_W_P'(i);
          grant[i] = 1'b1;
        end else if (valid_0 && !valid_1 && limit >= 2'd2) begin
          valid_1  = 1'b1;
          idx_1    = PREG_W_P'(i);
          grant[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/general_register_freelist.sv
// Circular FIFO of free physical register names: up to two releases and two
// allocations per cycle, with restart/flush clearing the list.
module general_register_freelist
  import general_register_freelist_pkg::*;
#(
  parameter int PREG_NUM = general_register_freelist_pkg::PREG_NUM,
  parameter int PREG_W   = general_register_freelist_pkg::PREG_W
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iFREE_RESTART,
  input  logic [PREG_NUM-1:0] iENTRY_FREELIST_REQ,
  output logic [PREG_NUM-1:0] oENTRY_FREELIST_REGIST_VALID,
  input  logic                iALLOC_0_REQ,
  input  logic                iALLOC_1_REQ,
  output logic                oALLOC_0_VALID,
  output logic [PREG_W-1:0]   oALLOC_0_REGNAME,
  output logic                oALLOC_1_VALID,
  output logic [PREG_W-1:0]   oALLOC_1_REGNAME,
  output logic [PREG_W:0]     oFREE_COUNT
);

  localparam int CW = PREG_W + 1;
  localparam int RW = PREG_W + 2;

  logic [PREG_W-1:0] fifo_q [PREG_NUM];
  logic [PREG_W-1:0] fifo_d [PREG_NUM];
  logic [PREG_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              run;
  logic              pop0, pop1;
  logic [1:0]        npop, npush, limit;
  logic [RW-1:0]     room;
  logic              pv0, pv1;
  logic [PREG_W-1:0] pidx0, pidx1;

  // Restart and reset both mask every grant and allocation this cycle.
  assign run            = inRESET && !iFREE_RESTART;
  assign oALLOC_0_VALID = run && (count_q >= CW'(1));
  assign oALLOC_1_VALID = run && (count_q >= CW'(2));
  assign oALLOC_0_REGNAME = inRESET ? fifo_q[rptr_q] : '0;
  assign oALLOC_1_REGNAME = inRESET ? fifo_q[rptr_q + PREG_W'(1)] : '0;
  assign oFREE_COUNT    = count_q;

  assign pop0  = iALLOC_0_REQ && oALLOC_0_VALID;
  assign pop1  = iALLOC_1_REQ && oALLOC_1_VALID && pop0;
  assign npop  = {1'b0, pop0} + {1'b0, pop1};
  assign npush = {1'b0, pv0} + {1'b0, pv1};

  // Free slots this cycle include the ones vacated by same-cycle pops.
  assign room  = RW'(PREG_NUM) - RW'(count_q) + RW'(npop);
  assign limit = !run ? 2'd0 : (room >= RW'(2)) ? 2'd2 : room[1:0];

  general_register_freelist_pick2 #(
    .PREG_NUM_P (PREG_NUM),
    .PREG_W_P   (PREG_W)
  ) u_pick2 (
    .req     (iENTRY_FREELIST_REQ),
    .limit   (limit),
    .valid_0 (pv0),
    .valid_1 (pv1),
    .idx_0   (pidx0),
    .idx_1   (pidx1),
    .grant   (oENTRY_FREELIST_REGIST_VALID)
  );

  always_comb begin
    fifo_d = fifo_q;
    if (pv0) fifo_d[wptr_q] = pidx0;
    if (pv1) fifo_d[wptr_q + PREG_W'(1)] = pidx1;
    if (iFREE_RESTART) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      rptr_d  = rptr_q + PREG_W'(npop);
      wptr_d  = wptr_q + PREG_W'(npush);
      count_d = count_q + CW'(npush) - CW'(npop);
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      fifo_q  <= '{default: '0};
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      fifo_q  <= fifo_d;
    end
  end

endmodule
